// File: rtl/ic_slv_arb_pkg.sv
// Shared fabric constants and arbitration helpers for the AXI interconnect.
package ic_slv_arb_pkg;

    localparam int MSTR_NUM  = 4;
    localparam int MSTR_BITS = (MSTR_NUM > 1) ? $clog2(MSTR_NUM) : 1;
    localparam int SLV_NUM   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [MSTR_BITS-1:0] idx;
    } rr_res_t;

    // Encode a one-hot master vector into its index (zero when no bit is set).
    function automatic logic [MSTR_BITS-1:0] onehot2idx(input logic [MSTR_NUM-1:0] oh);
        logic [MSTR_BITS-1:0] idx;
        idx = '0;
        for (int i = 0; i < MSTR_NUM; i++) begin
            if (oh[i]) idx = idx | MSTR_BITS'(i);
        end
        return idx;
    endfunction

    // First requester after 'last' in rotating order; 'last' itself is checked last.
    function automatic rr_res_t rr_search(input logic [MSTR_NUM-1:0] req,
                                          input logic [MSTR_BITS-1:0] last);
        rr_res_t              res;
        int                   cand;
        logic [MSTR_BITS-1:0] c;
        res = '0;
        for (int i = 1; i <= MSTR_NUM; i++) begin
            cand = (int'(last) + i) % MSTR_NUM;
            c    = MSTR_BITS'(cand);
            if (!res.found && req[c]) begin
                res.found = 1'b1;
                res.idx   = c;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ic_slv_arb_fifo.sv
// Order FIFO: records which master owns each accepted write address, in order.
module ic_ord_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int ABITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic [ABITS:0]   o_count,
    output logic             o_underflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ABITS-1:0] r_wptr;
    logic [ABITS-1:0] r_rptr;
    logic [ABITS:0]   r_count;
    logic             r_underflow;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == (ABITS+1)'(DEPTH));
    assign o_count     = r_count;
    assign o_underflow = r_underflow;
    assign o_dout      = o_empty ? '0 : r_mem[r_rptr];
    assign w_push_ok   = i_push & ~o_full;
    assign w_pop_ok    = i_pop & ~o_empty;

    // Pointers, occupancy and sticky underflow flag; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{ABITS{1'b0}}, w_push_ok} - {{ABITS{1'b0}}, w_pop_ok};
            if (i_pop && o_empty) r_underflow <= 1'b1;
        end
    end

    // Entry storage; contents are only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/ic_slv_arb.sv
// Per-slave round-robin address-channel arbiter with optional write-order FIFO.
module ic_slv_arb
    import ic_slv_arb_pkg::*;
#(
    parameter int MSTR_NUM   = ic_slv_arb_pkg::MSTR_NUM,
    parameter int MSTR_BITS  = ic_slv_arb_pkg::MSTR_BITS,
    parameter int ORDER_EN   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MSTR_NUM-1:0]  req,
    input  logic                 slv_aready,
    output logic                 slv_avalid,
    output logic [MSTR_NUM-1:0]  grant,
    output logic [MSTR_BITS-1:0] grant_mstr,
    input  logic                 w_last_hs,
    output logic [MSTR_BITS-1:0] w_mstr,
    output logic                 w_mstr_valid,
    output logic                 order_err
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [MSTR_NUM-1:0]  r_grant;
    logic [MSTR_NUM-1:0]  w_grant_nxt;
    logic [MSTR_BITS-1:0] r_grant_mstr;
    logic [MSTR_BITS-1:0] w_grant_mstr_nxt;
    logic [MSTR_BITS-1:0] r_last_ptr;
    logic [MSTR_BITS-1:0] w_last_ptr_nxt;
    logic [MSTR_BITS-1:0] w_base;
    logic [MSTR_NUM-1:0]  w_onehot;
    rr_res_t              w_sel;
    logic                 w_hs;
    logic                 w_pop_eff;
    logic [FIFO_BITS:0]   w_cnt;
    logic [FIFO_BITS:0]   w_cnt_nxt;
    logic                 w_fifo_ok;

    assign slv_avalid = (r_state == ST_GRANT);
    assign grant      = r_grant;
    assign grant_mstr = r_grant_mstr;
    assign w_hs       = (r_state == ST_GRANT) & slv_aready;

    generate
        if (ORDER_EN != 0) begin : g_order
            logic w_empty;
            logic w_full;
            ic_ord_fifo #(
                .WIDTH (MSTR_BITS),
                .DEPTH (FIFO_DEPTH),
                .ABITS (FIFO_BITS)
            ) u_fifo (
                .clk         (clk),
                .reset       (reset),
                .i_push      (w_hs),
                .i_din       (r_grant_mstr),
                .i_pop       (w_last_hs),
                .o_dout      (w_mstr),
                .o_empty     (w_empty),
                .o_full      (w_full),
                .o_count     (w_cnt),
                .o_underflow (order_err)
            );
            assign w_mstr_valid = ~w_empty;
            assign w_pop_eff    = w_last_hs & ~w_empty;
            // Occupancy after this cycle's push/pop decides whether another address fits.
            assign w_cnt_nxt    = w_cnt + {{FIFO_BITS{1'b0}}, w_hs} - {{FIFO_BITS{1'b0}}, w_pop_eff};
            assign w_fifo_ok    = (w_cnt_nxt < (FIFO_BITS+1)'(FIFO_DEPTH));
        end else begin : g_no_order
            assign w_mstr       = '0;
            assign w_mstr_valid = 1'b0;
            assign order_err    = 1'b0;
            assign w_cnt        = '0;
            assign w_pop_eff    = 1'b0;
            assign w_cnt_nxt    = '0;
            assign w_fifo_ok    = 1'b1;
        end
    endgenerate

    // Search starts after the master served this cycle, so it drops to lowest priority.
    assign w_base = w_hs ? r_grant_mstr : r_last_ptr;
    assign w_sel  = rr_search(req, w_base);

    // State and grant registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_grant_mstr <= '0;
            r_last_ptr   <= MSTR_BITS'(MSTR_NUM - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_grant_mstr <= w_grant_mstr_nxt;
            r_last_ptr   <= w_last_ptr_nxt;
        end
    end

    // Next-state: grant from IDLE, hold until handshake, then chain or release.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_grant_mstr_nxt = r_grant_mstr;
        w_last_ptr_nxt   = r_last_ptr;
        w_onehot         = '0;
        w_onehot[w_sel.idx] = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_sel.found && w_fifo_ok) begin
                    w_state_nxt      = ST_GRANT;
                    w_grant_nxt      = w_onehot;
                    w_grant_mstr_nxt = w_sel.idx;
                end
            end
            ST_GRANT: begin
                if (w_hs) begin
                    w_last_ptr_nxt = r_grant_mstr;
                    if (w_sel.found && w_fifo_ok) begin
                        w_grant_nxt      = w_onehot;
                        w_grant_mstr_nxt = w_sel.idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ic_slv_arb.sv
// Directed bench for ic_slv_arb: grant timing, rotation, hold, FIFO fill/wrap, errors, reset.
module tb_ic_slv_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       slv_aready;
    logic       slv_avalid;
    logic [3:0] grant;
    logic [1:0] grant_mstr;
    logic       w_last_hs;
    logic [1:0] w_mstr;
    logic       w_mstr_valid;
    logic       order_err;

    int tests = 0;
    int fails = 0;

    ic_slv_arb #(
        .MSTR_NUM   (4),
        .MSTR_BITS  (2),
        .ORDER_EN   (1),
        .FIFO_DEPTH (4),
        .FIFO_BITS  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .slv_aready   (slv_aready),
        .slv_avalid   (slv_avalid),
        .grant        (grant),
        .grant_mstr   (grant_mstr),
        .w_last_hs    (w_last_hs),
        .w_mstr       (w_mstr),
        .w_mstr_valid (w_mstr_valid),
        .order_err    (order_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; slv_aready = 1'b0; w_last_hs = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (slv_avalid !== 1'b0) begin fails++; $display("FAIL rst_avalid got %b exp 0", slv_avalid); end
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL rst_grant got %b exp 0000", grant); end
        tests++; if (grant_mstr !== 2'd0) begin fails++; $display("FAIL rst_gmstr got %0d exp 0", grant_mstr); end
        tests++; if (w_mstr_valid !== 1'b0) begin fails++; $display("FAIL rst_wvalid got %b exp 0", w_mstr_valid); end
        tests++; if (w_mstr !== 2'd0) begin fails++; $display("FAIL rst_wmstr got %0d exp 0", w_mstr); end
        tests++; if (order_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", order_err); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; slv_aready = 1'b1;
        step();
        tests++; if (slv_avalid !== 1'b1) begin fails++; $display("FAIL single_avalid got %b exp 1", slv_avalid); end
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL single_grant got %b exp 0100", grant); end
        tests++; if (grant_mstr !== 2'd2) begin fails++; $display("FAIL single_gmstr got %0d exp 2", grant_mstr); end
        tests++; if (w_mstr_valid !== 1'b0) begin fails++; $display("FAIL single_wvalid_pre got %b exp 0", w_mstr_valid); end
        req = 4'b0000;
        step();
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL single_grant_off got %b exp 0000", grant); end
        tests++; if (slv_avalid !== 1'b0) begin fails++; $display("FAIL single_avalid_off got %b exp 0", slv_avalid); end
        tests++; if (w_mstr_valid !== 1'b1) begin fails++; $display("FAIL single_wvalid got %b exp 1", w_mstr_valid); end
        tests++; if (w_mstr !== 2'd2) begin fails++; $display("FAIL single_wmstr got %0d exp 2", w_mstr); end
        w_last_hs = 1'b1;
        step();
        w_last_hs = 1'b0;
        tests++; if (w_mstr_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b exp 0", w_mstr_valid); end
        tests++; if (order_err !== 1'b0) begin fails++; $display("FAIL single_err got %b exp 0", order_err); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111; slv_aready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++; if (grant_mstr !== exp_seq[i]) begin fails++; $display("FAIL rr_gmstr[%0d] got %0d exp %0d", i, grant_mstr, exp_seq[i]); end
            tests++; if (slv_avalid !== 1'b1) begin fails++; $display("FAIL rr_avalid[%0d] got %b exp 1", i, slv_avalid); end
            if (i >= 1) begin
                tests++; if (w_mstr !== exp_seq[i-1]) begin fails++; $display("FAIL rr_wmstr[%0d] got %0d exp %0d", i, w_mstr, exp_seq[i-1]); end
                w_last_hs = 1'b1;
            end
        end
        w_last_hs = 1'b0;
        tests++; if (order_err !== 1'b0) begin fails++; $display("FAIL rr_err got %b exp 0", order_err); end
    endtask

    task automatic test_hold();
        do_reset();
        req = 4'b0011; slv_aready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL hold_grant[%0d] got %b exp 0001", i, grant); end
            tests++; if (w_mstr_valid !== 1'b0) begin fails++; $display("FAIL hold_nopush[%0d] got %b exp 0", i, w_mstr_valid); end
        end
        slv_aready = 1'b1;
        step();
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL hold_next_grant got %b exp 0010", grant); end
        tests++; if (grant_mstr !== 2'd1) begin fails++; $display("FAIL hold_next_gmstr got %0d exp 1", grant_mstr); end
        tests++; if (w_mstr_valid !== 1'b1 || w_mstr !== 2'd0) begin fails++; $display("FAIL hold_push got v=%b m=%0d exp v=1 m=0", w_mstr_valid, w_mstr); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        req = 4'b0001; slv_aready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (slv_avalid !== 1'b1) begin fails++; $display("FAIL full_avalid[%0d] got %b exp 1", i, slv_avalid); end
        end
        step();
        tests++; if (slv_avalid !== 1'b0) begin fails++; $display("FAIL full_stop got %b exp 0", slv_avalid); end
        step();
        tests++; if (slv_avalid !== 1'b0 || grant !== 4'b0000) begin fails++; $display("FAIL full_blocked got v=%b g=%b exp v=0 g=0000", slv_avalid, grant); end
        tests++; if (w_mstr !== 2'd0 || w_mstr_valid !== 1'b1) begin fails++; $display("FAIL full_head got v=%b m=%0d exp v=1 m=0", w_mstr_valid, w_mstr); end
        w_last_hs = 1'b1;
        step();
        w_last_hs = 1'b0;
        tests++; if (slv_avalid !== 1'b1 || grant !== 4'b0001) begin fails++; $display("FAIL full_regrant got v=%b g=%b exp v=1 g=0001", slv_avalid, grant); end
        step();
        tests++; if (slv_avalid !== 1'b0) begin fails++; $display("FAIL full_refill got %b exp 0", slv_avalid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] q[$];
        logic [1:0] g;
        do_reset();
        req = 4'b1111; slv_aready = 1'b1;
        step();
        g = 2'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            q.push_back(g);
            g = g + 2'd1;
            tests++; if (grant_mstr !== g) begin fails++; $display("FAIL b2b_fill_gmstr[%0d] got %0d exp %0d", k, grant_mstr, g); end
        end
        for (int k = 0; k < 10; k++) begin
            w_last_hs = 1'b1;
            step();
            q.push_back(g);
            void'(q.pop_front());
            g = g + 2'd1;
            tests++; if (slv_avalid !== 1'b1 || grant_mstr !== g) begin fails++; $display("FAIL b2b_grant[%0d] got v=%b m=%0d exp v=1 m=%0d", k, slv_avalid, grant_mstr, g); end
            tests++; if (w_mstr_valid !== 1'b1 || w_mstr !== q[0]) begin fails++; $display("FAIL b2b_head[%0d] got v=%b m=%0d exp v=1 m=%0d", k, w_mstr_valid, w_mstr, q[0]); end
        end
        w_last_hs = 1'b0;
        tests++; if (order_err !== 1'b0) begin fails++; $display("FAIL b2b_err got %b exp 0", order_err); end
    endtask

    task automatic test_order_err_and_reset();
        do_reset();
        w_last_hs = 1'b1;
        step();
        w_last_hs = 1'b0;
        tests++; if (order_err !== 1'b1) begin fails++; $display("FAIL err_set got %b exp 1", order_err); end
        tests++; if (w_mstr_valid !== 1'b0) begin fails++; $display("FAIL err_wvalid got %b exp 0", w_mstr_valid); end
        step();
        step();
        tests++; if (order_err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", order_err); end
        req = 4'b0100; slv_aready = 1'b0;
        step();
        tests++; if (slv_avalid !== 1'b1 || grant_mstr !== 2'd2) begin fails++; $display("FAIL mid_setup got v=%b m=%0d exp v=1 m=2", slv_avalid, grant_mstr); end
        reset = 1'b1; slv_aready = 1'b1; req = 4'b1111;
        step();
        reset = 1'b0;
        tests++; if (slv_avalid !== 1'b0 || grant !== 4'b0000 || grant_mstr !== 2'd0) begin fails++; $display("FAIL mid_rst_arb got v=%b g=%b m=%0d exp v=0 g=0000 m=0", slv_avalid, grant, grant_mstr); end
        tests++; if (w_mstr_valid !== 1'b0 || w_mstr !== 2'd0) begin fails++; $display("FAIL mid_rst_nopush got v=%b m=%0d exp v=0 m=0", w_mstr_valid, w_mstr); end
        tests++; if (order_err !== 1'b0) begin fails++; $display("FAIL mid_rst_err got %b exp 0", order_err); end
        step();
        tests++; if (grant !== 4'b0001 || grant_mstr !== 2'd0) begin fails++; $display("FAIL mid_rst_first got g=%b m=%0d exp g=0001 m=0", grant, grant_mstr); end
    endtask

    initial begin
        reset = 1'b1; req = '0; slv_aready = 1'b0; w_last_hs = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_fifo_full();
        test_back_to_back();
        test_order_err_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ic_slv_arb.md
Name: ic_slv_arb

Overview:
- Per-slave address-channel arbiter for the AXI interconnect fabric. One instance sits in front of each slave port's AW or AR channel.
- Shares the slave port between MSTR_NUM masters using round-robin. Drives the slave-side master-select index consumed by the address mux.
- When ORDER_EN=1 (AW instance), it records the granted master per accepted address in an order FIFO. The write-data router uses this FIFO to steer W beats to the slave in address order.

Parameters:
MSTR_NUM, 4, number of master ports competing for this slave
MSTR_BITS, 2, width of master index, ceil(log2(MSTR_NUM)), minimum 1
ORDER_EN, 1, 1 = build order FIFO (AW use), 0 = no FIFO (AR use)
FIFO_DEPTH, 4, order FIFO entries, power of two
FIFO_BITS, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
req  in  MSTR_NUM  per-master AVALID already decoded to this slave
slv_aready  in  1  slave AREADY
slv_avalid  out  1  AVALID presented to slave
grant  out  MSTR_NUM  one-hot grant; also returned as AREADY to masters when ANDed with slv_aready
grant_mstr  out  MSTR_BITS  encoded granted master (slave AMSTR)
w_last_hs  in  1  slave-side WVALID&WREADY&WLAST
w_mstr  out  MSTR_BITS  master owning current write burst (FIFO head)
w_mstr_valid  out  1  FIFO non-empty
order_err  out  1  sticky: pop on empty FIFO

Behaviour:
- Reset (clk edge with reset=1): grant=0, slv_avalid=0, grant_mstr=0, last_ptr=MSTR_NUM-1 (master 0 wins first), FIFO empty, w_mstr_valid=0, w_mstr=0, order_err=0. Reset mid-grant aborts with no push.
- State machine, two states:
  - IDLE: slv_avalid=0. If any req and (!ORDER_EN or FIFO not full), select the first requesting master searching last_ptr+1, last_ptr+2, … modulo MSTR_NUM. Register grant/grant_mstr and go to GRANT. Latency req→slv_avalid is 1 cycle.
  - GRANT: slv_avalid=1. Grant is held stable until slv_aready=1; the master's req must stay high (AXI rule), and a drop of req is a bench assertion failure, not handled.
  - On handshake (slv_avalid & slv_aready):
    - last_ptr←grant_mstr.
    - If ORDER_EN, push grant_mstr into the FIFO.
    - Re-arbitrate the same cycle, excluding the just-served master only via the rotating priority.
    - If another eligible req exists and the FIFO will not be full after the push, stay in GRANT with the new grant (back-to-back, 1 address/cycle). Otherwise go to IDLE with grant=0.
- FIFO eligibility uses the post-push/post-pop count: with count=FIFO_DEPTH-1, push and pop in the same cycle, a new grant is allowed.
- Order FIFO (ORDER_EN=1):
  - Push on address handshake; pop on w_last_hs.
  - Simultaneous push+pop: count unchanged, head advances, write and read pointers wrap modulo FIFO_DEPTH.
  - Pop when empty is ignored and sets order_err (cleared only by reset).
  - Push when full cannot occur, because the grant is blocked.
  - w_mstr = head entry, registered storage. w_mstr_valid = count!=0. The first push is visible on w_mstr_valid the cycle after the handshake.
- ORDER_EN=0: FIFO absent, w_mstr_valid=0, w_mstr=0, order_err=0 constant, w_last_hs ignored.
- Arithmetic:
  - Count width FIFO_BITS+1.
  - Index arithmetic is MSTR_BITS wide, with explicit modulo for MSTR_NUM not a power of two.

Decomposition:
- Shared package: MSTR_NUM, MSTR_BITS, SLV_NUM, the onehot-to-index function, and the round-robin search function; these are reused by the other arbiters in the fabric.
- One natural sub-module: ic_ord_fifo (synchronous FIFO, parameter width/depth, push/pop/full/empty/count).
- Arbitration and FSM stay in ic_slv_arb.

Test Plan:
- Single req=4'b0100, slv_aready=1 → cycle+1 slv_avalid=1, grant=0100, grant_mstr=2; cycle+2 grant=0; FIFO head w_mstr=2, w_mstr_valid=1.
- req=4'b1111 held, slv_aready=1 from reset → grant_mstr sequence 0,1,2,3,0 on consecutive cycles (FIFO drained by w_last_hs each cycle).
- req=4'b0011, slv_aready low 3 cycles → grant=0001 stable 4 cycles, then master 1 next; no push while ready low.
- ORDER_EN=1, FIFO_DEPTH=4, no w_last_hs, req=4'b0001 always → 4 handshakes then slv_avalid=0. One w_last_hs → regrant next cycle. w_mstr order matches grant order.
- FIFO count=3, handshake and w_last_hs same cycle → count stays 3, new grant issued, pointers wrap correctly over 10 iterations.
- w_last_hs with FIFO empty → order_err=1 sticky. Reset asserted while slv_avalid=1 → next cycle all outputs at reset values, order_err=0, first grant goes to master 0.
